// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase scheduler: phase selectors, FSM states,
// approach directions and the watchdog limit used when PHASE_TIMEOUT_EN is defined.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_GREEN_NS = 2'b00,
      PH_GREEN_EW = 2'b01,
      PH_PED_NS   = 2'b10,
      PH_PED_EW   = 2'b11
   } phase_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DECIDE = 2'b01,
      ST_REQ    = 2'b10,
      ST_WAIT   = 2'b11
   } state_t;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   localparam int TIMEOUT = 64;

   // Phase code is {pedestrian, direction}, which lets the decision logic build it directly.
   function automatic phase_t make_phase(input logic ped, input logic dir);
      return phase_t'({ped, dir});
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_request_latch.sv
// Sticky request latches: pedestrian buttons per approach and the vehicle overload flag.
// A set pulse on the same cycle as the clearing ack keeps the bit set.
module phase_request_latch
   import traffic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       button_NS,
   input  logic       button_EW,
   input  logic       vehicle_overload,
   input  logic       ack_fire,
   input  phase_t     ack_sel,
   output logic [1:0] ped_pend,
   output logic       ovl_lat
);

   logic clr_ped_ns;
   logic clr_ped_ew;
   logic clr_ovl;

   assign clr_ped_ns = ack_fire && (ack_sel == PH_PED_NS);
   assign clr_ped_ew = ack_fire && (ack_sel == PH_PED_EW);
   assign clr_ovl    = ack_fire && ((ack_sel == PH_GREEN_NS) || (ack_sel == PH_GREEN_EW));

   // NOTE: state is updated with <= so every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ped_pend <= 2'b00;
         ovl_lat  <= 1'b0;
      end else begin
         // NOTE: the set term is ORed outside the clear mask, so set beats a simultaneous clear.
         ped_pend[DIR_NS] <= button_NS | (ped_pend[DIR_NS] & ~clr_ped_ns);
         ped_pend[DIR_EW] <= button_EW | (ped_pend[DIR_EW] & ~clr_ped_ew);
         ovl_lat          <= vehicle_overload | (ovl_lat & ~clr_ovl);
      end
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Phase sequencer above the light controller: picks the next phase with fair NS/EW
// alternation and bounded skipping. Define PHASE_TIMEOUT_EN to build the WAIT watchdog.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter logic [4:0] DUR_GREEN = 5'd10,
   parameter logic [4:0] DUR_LONG  = 5'd20,
   parameter logic [4:0] DUR_PED   = 5'd8,
   parameter int         MAX_SKIP  = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       button_NS,
   input  logic       button_EW,
   input  logic       sense_NS,
   input  logic       sense_EW,
   input  logic       vehicle_overload,
   input  logic       phase_ack,
   input  logic       phase_done,
   output logic       phase_req,
   output logic [1:0] phase_sel,
   output logic [4:0] phase_dur,
   output logic [1:0] ped_pend,
   output logic       fault
);

   state_t     state, state_nxt;
   phase_t     sel_q, sel_nxt;
   logic [4:0] dur_q, dur_nxt;
   logic       last_dir, last_dir_nxt;
   logic [1:0] skip_cnt, skip_nxt;
   logic       ovl_lat;
   logic       ack_fire;
   logic       timeout;
   logic [1:0] sense_v;
   logic       nd;
   logic       od;
   logic [4:0] green_dur;

   assign ack_fire  = (state == ST_REQ) && phase_ack;
   assign sense_v   = {sense_EW, sense_NS};
   assign nd        = ~last_dir;
   assign od        = last_dir;
   assign green_dur = ovl_lat ? DUR_LONG : DUR_GREEN;

   phase_request_latch u_latch (
      .clk              (clk),
      .rst              (rst),
      .button_NS        (button_NS),
      .button_EW        (button_EW),
      .vehicle_overload (vehicle_overload),
      .ack_fire         (ack_fire),
      .ack_sel          (sel_q),
      .ped_pend         (ped_pend),
      .ovl_lat          (ovl_lat)
   );

`ifdef PHASE_TIMEOUT_EN
   logic [6:0] wd_cnt;
   logic       fault_q;

   assign timeout = (state == ST_WAIT) && !phase_done && (wd_cnt == 7'(TIMEOUT - 1));
   assign fault   = fault_q;

   // Counter is held at zero outside WAIT, so it restarts on every entry to WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt  <= '0;
         fault_q <= 1'b0;
      end else begin
         if (state != ST_WAIT) wd_cnt <= '0;
         else                  wd_cnt <= wd_cnt + 7'd1;
         if (timeout) fault_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign fault   = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel_q;
      dur_nxt      = dur_q;
      last_dir_nxt = last_dir;
      skip_nxt     = skip_cnt;
      unique case (state)
         ST_IDLE: begin
            if (en) state_nxt = ST_DECIDE;
         end
         ST_DECIDE: begin
            state_nxt = ST_REQ;
            if (ped_pend[nd]) begin
               sel_nxt      = make_phase(1'b1, nd);
               dur_nxt      = DUR_PED;
               last_dir_nxt = nd;
               skip_nxt     = 2'd0;
            end else if (!sense_v[nd] && sense_v[od] && (skip_cnt < 2'(MAX_SKIP))) begin
               // Empty approach skipped: serve the busy one again without flipping direction.
               sel_nxt  = make_phase(1'b0, od);
               dur_nxt  = green_dur;
               skip_nxt = skip_cnt + 2'd1;
            end else begin
               sel_nxt      = make_phase(1'b0, nd);
               dur_nxt      = green_dur;
               last_dir_nxt = nd;
               skip_nxt     = 2'd0;
            end
         end
         ST_REQ: begin
            if (phase_ack) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (phase_done)   state_nxt = en ? ST_DECIDE : ST_IDLE;
            else if (timeout) state_nxt = ST_DECIDE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         sel_q    <= PH_GREEN_NS;
         dur_q    <= 5'd0;
         last_dir <= DIR_EW;
         skip_cnt <= 2'd0;
      end else begin
         state    <= state_nxt;
         sel_q    <= sel_nxt;
         dur_q    <= dur_nxt;
         last_dir <= last_dir_nxt;
         skip_cnt <= skip_nxt;
      end
   end

   assign phase_req = (state == ST_REQ);
   assign phase_sel = sel_q;
   assign phase_dur = dur_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: stimulus pushes the expected phase of each
// transfer into a queue, a negedge monitor pops and compares on every req/ack transfer.
module tb_traffic_phase_scheduler;

   typedef struct {
      logic [1:0] sel;
      logic [4:0] dur;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       button_NS = 1'b0;
   logic       button_EW = 1'b0;
   logic       sense_NS = 1'b0;
   logic       sense_EW = 1'b0;
   logic       vehicle_overload = 1'b0;
   logic       phase_ack = 1'b0;
   logic       phase_done = 1'b0;
   logic       phase_req;
   logic [1:0] phase_sel;
   logic [4:0] phase_dur;
   logic [1:0] ped_pend;
   logic       fault;

   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];

   traffic_phase_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .en               (en),
      .button_NS        (button_NS),
      .button_EW        (button_EW),
      .sense_NS         (sense_NS),
      .sense_EW         (sense_EW),
      .vehicle_overload (vehicle_overload),
      .phase_ack        (phase_ack),
      .phase_done       (phase_done),
      .phase_req        (phase_req),
      .phase_sel        (phase_sel),
      .phase_dur        (phase_dur),
      .ped_pend         (ped_pend),
      .fault            (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: each accepted phase must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && phase_req && phase_ack) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL xfer_unexpected: got sel=%0d dur=%0d with empty queue", phase_sel, phase_dur);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (phase_sel !== e.sel || phase_dur !== e.dur) begin
               bad++;
               $display("FAIL xfer: got sel=%0d dur=%0d expected sel=%0d dur=%0d",
                        phase_sel, phase_dur, e.sel, e.dur);
            end
         end
      end
   end

   task automatic expect_phase(input logic [1:0] sel, input logic [4:0] dur);
      exp_t e;
      e.sel = sel;
      e.dur = dur;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; acks after 'hold' extra request cycles, optionally with button_NS.
   task automatic serve_ack(input int hold, input logic btn_ns);
      int n = 0;
      while (!phase_req && n < 32) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_seen", 32'(phase_req), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_req", 32'(phase_req), 32'd1);
         if (exp_q.size() > 0) begin
            check("hold_sel", 32'(phase_sel), 32'(exp_q[0].sel));
            check("hold_dur", 32'(phase_dur), 32'(exp_q[0].dur));
         end
      end
      phase_ack = 1'b1;
      button_NS = btn_ns;
      @(posedge clk); #1;
      phase_ack = 1'b0;
      button_NS = 1'b0;
   endtask

   task automatic finish_done(input int gap);
      repeat (gap) begin
         @(posedge clk); #1;
      end
      phase_done = 1'b1;
      @(posedge clk); #1;
      phase_done = 1'b0;
   endtask

   task automatic run_phase(input logic [1:0] sel, input logic [4:0] dur);
      expect_phase(sel, dur);
      serve_ack(0, 1'b0);
      finish_done(2);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int n;
      sense_NS = 1'b1;
      sense_EW = 1'b1;
      en       = 1'b1;
      #22;
      check("rst_req",   32'(phase_req), 32'd0);
      check("rst_sel",   32'(phase_sel), 32'd0);
      check("rst_dur",   32'(phase_dur), 32'd0);
      check("rst_ped",   32'(ped_pend),  32'd0);
      check("rst_fault", 32'(fault),     32'd0);

      // Reset release to first request: IDLE, DECIDE, then REQ.
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("lat_decide_req", 32'(phase_req), 32'd0);
      expect_phase(2'b00, 5'd10);
      @(posedge clk); #1;
      check("lat_first_req", 32'(phase_req), 32'd1);
      serve_ack(0, 1'b0);
      check("req_drop_after_ack", 32'(phase_req), 32'd0);
      finish_done(3);
      check("done_decide_req", 32'(phase_req), 32'd0);
      expect_phase(2'b01, 5'd10);
      @(posedge clk); #1;
      check("done_to_req", 32'(phase_req), 32'd1);
      serve_ack(0, 1'b0);
      finish_done(2);

      // Pedestrian request on EW during GREEN_NS.
      expect_phase(2'b00, 5'd10);
      serve_ack(0, 1'b0);
      button_EW = 1'b1;
      @(posedge clk); #1;
      button_EW = 1'b0;
      check("ped_ew_latched", 32'(ped_pend), 32'b10);
      finish_done(2);
      expect_phase(2'b11, 5'd8);
      serve_ack(0, 1'b0);
      check("ped_ew_cleared", 32'(ped_pend), 32'b00);
      finish_done(2);

      // Empty NS approach: two skips, forced NS, then a fresh skip window.
      run_phase(2'b00, 5'd10);
      sense_NS = 1'b0;
      run_phase(2'b01, 5'd10);
      run_phase(2'b01, 5'd10);
      run_phase(2'b01, 5'd10);
      run_phase(2'b00, 5'd10);
      run_phase(2'b01, 5'd10);
      run_phase(2'b01, 5'd10);
      sense_NS = 1'b1;

      // Overload pulse in WAIT lengthens exactly one following green.
      expect_phase(2'b00, 5'd10);
      serve_ack(0, 1'b0);
      vehicle_overload = 1'b1;
      @(posedge clk); #1;
      vehicle_overload = 1'b0;
      finish_done(1);
      run_phase(2'b01, 5'd20);
      expect_phase(2'b00, 5'd10);
      serve_ack(0, 1'b0);
      button_NS = 1'b1;
      @(posedge clk); #1;
      button_NS = 1'b0;
      check("ped_ns_latched", 32'(ped_pend), 32'b01);
      finish_done(1);

      // Held ack keeps the request stable; button on the PED_NS ack cycle survives.
      expect_phase(2'b01, 5'd10);
      serve_ack(5, 1'b0);
      finish_done(2);
      expect_phase(2'b10, 5'd8);
      serve_ack(0, 1'b1);
      check("ped_set_wins", 32'(ped_pend), 32'b01);
      finish_done(2);
      run_phase(2'b01, 5'd10);
      expect_phase(2'b10, 5'd8);
      serve_ack(0, 1'b0);
      check("ped_ns_cleared", 32'(ped_pend), 32'b00);

      // en=0 lets the phase finish, then parks in IDLE.
      en = 1'b0;
      finish_done(2);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("idle_parked", 32'(phase_req), 32'd0);
      end
      en = 1'b1;
      expect_phase(2'b01, 5'd10);
      serve_ack(0, 1'b0);

`ifdef PHASE_TIMEOUT_EN
      n = 0;
      while (!fault && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("wd_fault", 32'(fault), 32'd1);
      check("wd_cycles", 32'(n), 32'd64);
      check("wd_decide", 32'(phase_req), 32'd0);
      expect_phase(2'b00, 5'd10);
      @(posedge clk); #1;
      check("wd_to_req", 32'(phase_req), 32'd1);
      serve_ack(0, 1'b0);
`else
      n = 0;
      repeat (70) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_holds_req", 32'(phase_req), 32'd0);
      check("no_fault", 32'(fault), 32'd0);
`endif

      // Asynchronous reset in the middle of WAIT.
      button_EW = 1'b1;
      @(posedge clk); #1;
      button_EW = 1'b0;
      check("pre_rst_ped", 32'(ped_pend), 32'b10);
      #2;
      rst = 1'b0;
      #1;
      check("arst_req",   32'(phase_req), 32'd0);
      check("arst_sel",   32'(phase_sel), 32'd0);
      check("arst_dur",   32'(phase_dur), 32'd0);
      check("arst_ped",   32'(ped_pend),  32'd0);
      check("arst_fault", 32'(fault),     32'd0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
